// File: rtl/fft_ctrl_pkg.sv
// Shared definitions for the FFT framing controller: capture states,
// FFT core error codes and the bit layout of the FFT source data word.
package fft_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WAIT_SOP = 2'd1,
    ST_FILL     = 2'd2,
    ST_SKIP     = 2'd3
  } state_e;

  localparam logic [1:0] FFT_ERR_NONE           = 2'b00;
  localparam logic [1:0] FFT_ERR_MISSING_SOP    = 2'b01;
  localparam logic [1:0] FFT_ERR_MISSING_EOP    = 2'b10;
  localparam logic [1:0] FFT_ERR_UNEXPECTED_EOP = 2'b11;

  localparam int EXP_W    = 6;
  localparam int CPLX_W   = 16;
  localparam int EXP_LSB  = 0;
  localparam int REAL_LSB = 6;
  localparam int IMAG_LSB = 22;

endpackage

// File: rtl/fft_bin_tracker.sv
// Output-side bin counter and framing checker for FFT results; also keeps
// the completed-frame count and the sticky framing error flag.
module fft_bin_tracker #(
  parameter int FFT_LEN  = 1024,
  parameter int LOG2_LEN = 10
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                src_valid,
  input  logic                src_sop,
  input  logic                src_eop,
  input  logic [1:0]          src_error,
  input  logic                out_ready,
  input  logic                clr_status,
  output logic [LOG2_LEN-1:0] out_bin,
  output logic                out_last,
  output logic [15:0]         frame_cnt,
  output logic                frame_err
);

  localparam logic [LOG2_LEN-1:0] LAST_BIN = LOG2_LEN'(FFT_LEN - 1);

  logic [LOG2_LEN-1:0] bin;
  logic [LOG2_LEN-1:0] cur_bin;
  logic                beat;
  logic                framing_bad;

  // sop restarts the frame, so the sop beat itself is reported as bin 0
  assign cur_bin  = (src_valid && src_sop) ? '0 : bin;
  assign out_bin  = cur_bin;
  assign out_last = src_valid && (cur_bin == LAST_BIN);
  assign beat     = src_valid && out_ready;

  assign framing_bad = (out_last && !src_eop) ||
                       (!out_last && src_eop) ||
                       (src_sop && (bin != '0)) ||
                       (src_error != 2'b00);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bin       <= '0;
      frame_cnt <= '0;
      frame_err <= 1'b0;
    end else begin
      if (beat) begin
        bin <= out_last ? '0 : cur_bin + 1'b1;
      end
      if (clr_status) begin
        frame_cnt <= '0;
        frame_err <= 1'b0;
      end else begin
        if (beat && out_last) frame_cnt <= frame_cnt + 16'd1;
        if (beat && framing_bad) frame_err <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/fft_frame_ctrl.sv
// Frames a non-backpressurable ADC stream into FFT_LEN-point blocks for a
// streaming FFT core and tags/checks the FFT results on the way out.
module fft_frame_ctrl
  import fft_ctrl_pkg::*;
#(
  parameter int FFT_LEN  = 1024,
  parameter int LOG2_LEN = 10
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                cfg_enable,
  input  logic                cfg_continuous,
  input  logic [7:0]          cfg_skip,
  input  logic                start,
  input  logic                clr_status,
  input  logic                adc_valid,
  input  logic [31:0]         adc_data,
  output logic                fft_sink_valid,
  output logic                fft_sink_sop,
  output logic                fft_sink_eop,
  output logic [31:0]         fft_sink_data,
  output logic [1:0]          fft_sink_error,
  input  logic                fft_sink_ready,
  input  logic                fft_source_valid,
  input  logic                fft_source_sop,
  input  logic                fft_source_eop,
  input  logic [37:0]         fft_source_data,
  input  logic [1:0]          fft_source_error,
  output logic                fft_source_ready,
  output logic                out_valid,
  output logic                out_last,
  output logic [5:0]          out_exp,
  output logic [15:0]         out_real,
  output logic [15:0]         out_imag,
  output logic [LOG2_LEN-1:0] out_bin,
  input  logic                out_ready,
  output logic                busy,
  output logic                overrun,
  output logic                frame_err,
  output logic [15:0]         frame_cnt,
  output logic [1:0]          dbg_state
);

  // Handshakes: a sink beat transfers when fft_sink_valid is high, which already
  // includes fft_sink_ready; a result transfers when out_valid && out_ready.
  // The ADC side has no ready: unaccepted strobes are simply lost.

  localparam logic [LOG2_LEN-1:0] LAST_CNT = LOG2_LEN'(FFT_LEN - 1);

  state_e                state;
  logic [LOG2_LEN-1:0]   cnt;
  logic [LOG2_LEN+7:0]   skip_rem;
  logic                  stop_req;
  logic                  accept;
  logic                  in_frame;
  logic                  last_sample;

  assign accept      = adc_valid && fft_sink_ready;
  assign in_frame    = (state == ST_WAIT_SOP) || (state == ST_FILL);
  assign last_sample = (state == ST_FILL) && (cnt == LAST_CNT);

  assign fft_sink_valid = accept && in_frame;
  assign fft_sink_sop   = fft_sink_valid && (state == ST_WAIT_SOP);
  assign fft_sink_eop   = fft_sink_valid && last_sample;
  assign fft_sink_data  = adc_data;
  assign fft_sink_error = FFT_ERR_NONE;

  assign busy      = (state != ST_IDLE);
  assign dbg_state = state;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      skip_rem <= '0;
      stop_req <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      if (clr_status) overrun <= 1'b0;
      else if ((state == ST_FILL) && adc_valid && !fft_sink_ready) overrun <= 1'b1;

      case (state)
        ST_IDLE: begin
          stop_req <= 1'b0;
          if (cfg_enable && (start || cfg_continuous)) state <= ST_WAIT_SOP;
        end
        ST_WAIT_SOP: begin
          // a sop already emitted commits us to a full frame even if disabled
          if (accept) begin
            cnt      <= LOG2_LEN'(1);
            stop_req <= !cfg_enable;
            state    <= ST_FILL;
          end else if (!cfg_enable) begin
            state <= ST_IDLE;
          end
        end
        ST_FILL: begin
          if (!cfg_enable) stop_req <= 1'b1;
          if (accept) begin
            if (last_sample) begin
              cnt      <= '0;
              stop_req <= 1'b0;
              if (stop_req || !cfg_enable) begin
                state <= ST_IDLE;
              end else if (cfg_skip != 8'd0) begin
                skip_rem <= {cfg_skip, {LOG2_LEN{1'b0}}};
                state    <= ST_SKIP;
              end else begin
                state <= cfg_continuous ? ST_WAIT_SOP : ST_IDLE;
              end
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        ST_SKIP: begin
          if (!cfg_enable) begin
            skip_rem <= '0;
            state    <= ST_IDLE;
          end else if (adc_valid) begin
            if (skip_rem == (LOG2_LEN+8)'(1)) begin
              skip_rem <= '0;
              state    <= cfg_continuous ? ST_WAIT_SOP : ST_IDLE;
            end else begin
              skip_rem <= skip_rem - 1'b1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign out_valid        = fft_source_valid;
  assign fft_source_ready = out_ready;
  assign out_exp          = fft_source_data[EXP_LSB +: EXP_W];
  assign out_real         = fft_source_data[REAL_LSB +: CPLX_W];
  assign out_imag         = fft_source_data[IMAG_LSB +: CPLX_W];

  fft_bin_tracker #(
    .FFT_LEN  (FFT_LEN),
    .LOG2_LEN (LOG2_LEN)
  ) u_bin_tracker (
    .clk        (clk),
    .reset_n    (reset_n),
    .src_valid  (fft_source_valid),
    .src_sop    (fft_source_sop),
    .src_eop    (fft_source_eop),
    .src_error  (fft_source_error),
    .out_ready  (out_ready),
    .clr_status (clr_status),
    .out_bin    (out_bin),
    .out_last   (out_last),
    .frame_cnt  (frame_cnt),
    .frame_err  (frame_err)
  );

endmodule

// File: tb/tb_fft_frame_ctrl.sv
// Directed bench for fft_frame_ctrl with 16-point frames: capture modes,
// backpressure, disable mid-frame, result tagging and framing checks.
module tb_fft_frame_ctrl;
  import fft_ctrl_pkg::*;

  localparam int FFT_LEN  = 16;
  localparam int LOG2_LEN = 4;

  logic                clk = 1'b0;
  logic                reset_n;
  logic                cfg_enable;
  logic                cfg_continuous;
  logic [7:0]          cfg_skip;
  logic                start;
  logic                clr_status;
  logic                adc_valid;
  logic [31:0]         adc_data;
  logic                fft_sink_valid;
  logic                fft_sink_sop;
  logic                fft_sink_eop;
  logic [31:0]         fft_sink_data;
  logic [1:0]          fft_sink_error;
  logic                fft_sink_ready;
  logic                fft_source_valid;
  logic                fft_source_sop;
  logic                fft_source_eop;
  logic [37:0]         fft_source_data;
  logic [1:0]          fft_source_error;
  logic                fft_source_ready;
  logic                out_valid;
  logic                out_last;
  logic [5:0]          out_exp;
  logic [15:0]         out_real;
  logic [15:0]         out_imag;
  logic [LOG2_LEN-1:0] out_bin;
  logic                out_ready;
  logic                busy;
  logic                overrun;
  logic                frame_err;
  logic [15:0]         frame_cnt;
  logic [1:0]          dbg_state;

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] exp_q[$];
  logic [31:0] got_q[$];
  logic        got_sop[$];
  logic        got_eop[$];

  fft_frame_ctrl #(.FFT_LEN(FFT_LEN), .LOG2_LEN(LOG2_LEN)) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .cfg_enable       (cfg_enable),
    .cfg_continuous   (cfg_continuous),
    .cfg_skip         (cfg_skip),
    .start            (start),
    .clr_status       (clr_status),
    .adc_valid        (adc_valid),
    .adc_data         (adc_data),
    .fft_sink_valid   (fft_sink_valid),
    .fft_sink_sop     (fft_sink_sop),
    .fft_sink_eop     (fft_sink_eop),
    .fft_sink_data    (fft_sink_data),
    .fft_sink_error   (fft_sink_error),
    .fft_sink_ready   (fft_sink_ready),
    .fft_source_valid (fft_source_valid),
    .fft_source_sop   (fft_source_sop),
    .fft_source_eop   (fft_source_eop),
    .fft_source_data  (fft_source_data),
    .fft_source_error (fft_source_error),
    .fft_source_ready (fft_source_ready),
    .out_valid        (out_valid),
    .out_last         (out_last),
    .out_exp          (out_exp),
    .out_real         (out_real),
    .out_imag         (out_imag),
    .out_bin          (out_bin),
    .out_ready        (out_ready),
    .busy             (busy),
    .overrun          (overrun),
    .frame_err        (frame_err),
    .frame_cnt        (frame_cnt),
    .dbg_state        (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  // sink monitor: record every beat handed to the FFT core
  always @(negedge clk) begin
    if (reset_n && fft_sink_valid) begin
      got_q.push_back(fft_sink_data);
      got_sop.push_back(fft_sink_sop);
      got_eop.push_back(fft_sink_eop);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // driver tasks: inputs change 1ns after the rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe(input logic [31:0] d, input logic rdy);
    adc_valid      = 1'b1;
    adc_data       = d;
    fft_sink_ready = rdy;
    tick();
    adc_valid      = 1'b0;
    fft_sink_ready = 1'b1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic pulse_clr();
    clr_status = 1'b1;
    tick();
    clr_status = 1'b0;
  endtask

  // scoreboard: compare captured sink beats against exp_q, whole frames only
  task automatic check_frames(input string tag);
    int n;
    check({tag, "_beats"}, 32'(got_q.size()), 32'(exp_q.size()));
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      check({tag, "_data"}, got_q[i], exp_q[i]);
      check({tag, "_sop"}, 32'(got_sop[i]), 32'((i % FFT_LEN) == 0));
      check({tag, "_eop"}, 32'(got_eop[i]), 32'((i % FFT_LEN) == FFT_LEN - 1));
    end
    exp_q.delete();
    got_q.delete();
    got_sop.delete();
    got_eop.delete();
  endtask

  function automatic logic [37:0] src_word(input int k);
    logic [15:0] re;
    logic [15:0] im;
    logic [5:0]  ex;
    re = 16'h0100 + 16'(3 * k);
    im = 16'hA000 + 16'(k);
    ex = 6'(k + 5);
    return {im, re, ex};
  endfunction

  // one source beat; outputs are checked at the falling edge when chk is set
  task automatic src_beat(input int k, input logic sop, input logic eop,
                          input logic [1:0] err, input logic rdy, input logic chk,
                          input int exp_bin);
    fft_source_valid = 1'b1;
    fft_source_sop   = sop;
    fft_source_eop   = eop;
    fft_source_error = err;
    fft_source_data  = src_word(k);
    out_ready        = rdy;
    @(negedge clk);
    if (chk) begin
      check("out_bin", 32'(out_bin), 32'(exp_bin));
      check("out_last", 32'(out_last), 32'(exp_bin == FFT_LEN - 1));
      check("src_ready", 32'(fft_source_ready), 32'(rdy));
      if (rdy) begin
        check("out_valid", 32'(out_valid), 32'd1);
        check("out_real", 32'(out_real), 32'(16'h0100 + 16'(3 * k)));
        check("out_imag", 32'(out_imag), 32'(16'hA000 + 16'(k)));
        check("out_exp", 32'(out_exp), 32'(6'(k + 5)));
      end
    end
    @(posedge clk);
    #1;
    fft_source_valid = 1'b0;
    fft_source_sop   = 1'b0;
    fft_source_eop   = 1'b0;
    fft_source_error = 2'b00;
  endtask

  initial begin
    reset_n          = 1'b0;
    cfg_enable       = 1'b1;
    cfg_continuous   = 1'b0;
    cfg_skip         = 8'd0;
    start            = 1'b0;
    clr_status       = 1'b0;
    adc_valid        = 1'b1;
    adc_data         = 32'h0;
    fft_sink_ready   = 1'b1;
    fft_source_valid = 1'b0;
    fft_source_sop   = 1'b0;
    fft_source_eop   = 1'b0;
    fft_source_data  = '0;
    fft_source_error = 2'b00;
    out_ready        = 1'b0;

    // reset state, with an ADC strobe present that must not leak through
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    check("rst_overrun", 32'(overrun), 32'd0);
    check("rst_frame_err", 32'(frame_err), 32'd0);
    check("rst_frame_cnt", 32'(frame_cnt), 32'd0);
    check("rst_sink_valid", 32'(fft_sink_valid), 32'd0);
    check("rst_sink_error", 32'(fft_sink_error), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    reset_n   = 1'b1;
    adc_valid = 1'b0;
    tick();
    check("idle_no_start", 32'(busy), 32'd0);

    // single shot
    pulse_start();
    check("s1_busy", 32'(busy), 32'd1);
    for (int i = 0; i < 16; i++) begin
      strobe(32'h1000 + 32'(i), 1'b1);
      exp_q.push_back(32'h1000 + 32'(i));
    end
    check("s1_done_busy", 32'(busy), 32'd0);
    strobe(32'h1FFF, 1'b1);
    check("s1_overrun", 32'(overrun), 32'd0);
    check_frames("s1");

    // backpressure on strobes 6..8 (1-based) inside the frame
    pulse_start();
    for (int i = 1; i <= 19; i++) begin
      logic rdy;
      rdy = !(i >= 6 && i <= 8);
      strobe(32'h2000 + 32'(i), rdy);
      if (rdy) exp_q.push_back(32'h2000 + 32'(i));
    end
    check("s2_overrun", 32'(overrun), 32'd1);
    check("s2_busy", 32'(busy), 32'd0);
    check_frames("s2");
    pulse_clr();
    check("s2_overrun_clr", 32'(overrun), 32'd0);

    // enable dropped at sample 5: frame still completes, then idle
    pulse_start();
    for (int i = 1; i <= 20; i++) begin
      if (i == 5) cfg_enable = 1'b0;
      strobe(32'h3000 + 32'(i), 1'b1);
      if (i <= 16) exp_q.push_back(32'h3000 + 32'(i));
      if (i == 10) check("s4_busy_mid", 32'(busy), 32'd1);
    end
    check("s4_busy_end", 32'(busy), 32'd0);
    check_frames("s4");
    pulse_start();
    check("s4_start_disabled", 32'(busy), 32'd0);

    // continuous capture, skipping two frames between captures
    cfg_enable     = 1'b1;
    cfg_continuous = 1'b1;
    cfg_skip       = 8'd2;
    tick();
    for (int i = 1; i <= 80; i++) begin
      strobe(32'h4000 + 32'(i), 1'b1);
      if ((i >= 1 && i <= 16) || (i >= 49 && i <= 64)) exp_q.push_back(32'h4000 + 32'(i));
      if (i == 30) check("s3_skip_state", 32'(dbg_state), 32'(ST_SKIP));
    end
    cfg_enable = 1'b0;
    tick();
    check("s3_busy_off", 32'(busy), 32'd0);
    check_frames("s3");
    cfg_continuous = 1'b0;
    cfg_skip       = 8'd0;

    // output path: each bin presented with out_ready low, then high
    for (int k = 0; k < 16; k++) begin
      src_beat(k, k == 0, k == 15, 2'b00, 1'b0, 1'b1, k);
      src_beat(k, k == 0, k == 15, 2'b00, 1'b1, 1'b1, k);
    end
    out_ready = 1'b1;
    check("o_frame_cnt", 32'(frame_cnt), 32'd1);
    check("o_frame_err", 32'(frame_err), 32'd0);

    // early eop at bin 9
    for (int k = 0; k < 16; k++) begin
      src_beat(k, k == 0, k == 9, 2'b00, 1'b1, 1'b0, k);
      if (k == 8) check("e_err_before", 32'(frame_err), 32'd0);
      if (k == 9) check("e_err_after", 32'(frame_err), 32'd1);
    end
    check("e_frame_cnt", 32'(frame_cnt), 32'd2);
    pulse_clr();
    check("e_clr_err", 32'(frame_err), 32'd0);
    check("e_clr_cnt", 32'(frame_cnt), 32'd0);

    // sop arriving at bin 3 restarts at bin 0 and flags an error
    for (int k = 0; k < 3; k++) src_beat(k, k == 0, 1'b0, 2'b00, 1'b1, 1'b0, k);
    check("e_sop_ok", 32'(frame_err), 32'd0);
    src_beat(3, 1'b1, 1'b0, 2'b00, 1'b1, 1'b1, 0);
    check("e_sop_err", 32'(frame_err), 32'd1);
    pulse_clr();

    // nonzero error code on a valid beat; clr wins over a same-cycle set
    src_beat(1, 1'b0, 1'b0, 2'b10, 1'b1, 1'b0, 1);
    check("e_code_err", 32'(frame_err), 32'd1);
    clr_status = 1'b1;
    src_beat(2, 1'b0, 1'b0, 2'b01, 1'b1, 1'b0, 2);
    clr_status = 1'b0;
    check("e_clr_priority", 32'(frame_err), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fft_frame_ctrl.md
# fft_frame_ctrl

- Frames a continuous, non-backpressurable ADC sample stream into FFT_LEN-point blocks with correct SOP/EOP for the streaming FFT core.
- Supports single-shot, continuous and frame-decimated capture.
- Tags each FFT result with its bin index and checks output framing.
- Sits between the ADC capture front end and the FFT core (sink side), and between the FFT core and the spectrum consumer (source side).

## Interface
Parameters:
- FFT_LEN, 1024: points per frame; power of two, at least 4.
- LOG2_LEN, 10: log2(FFT_LEN).

Ports:
- clk  in  1  single clock for all logic.
- reset_n  in  1  asynchronous, active-low reset.
- cfg_enable  in  1  level; low stops capture.
- cfg_continuous  in  1  1 = re-arm automatically after each frame.
- cfg_skip  in  8  whole frames of ADC samples discarded between captured frames.
- start  in  1  one-cycle pulse; arms capture from IDLE.
- clr_status  in  1  one-cycle pulse; clears overrun, frame_err and frame_cnt.
- adc_valid  in  1  sample strobe; there is no backpressure on this input.
- adc_data  in  32  sample: imag in [31:16], real in [15:0].
- fft_sink_valid, fft_sink_sop, fft_sink_eop  out  1 each  to FFT sink.
- fft_sink_data  out  32  equal to adc_data.
- fft_sink_error  out  2  constant 2'b00.
- fft_sink_ready  in  1  from FFT.
- fft_source_valid, fft_source_sop, fft_source_eop  in  1 each  from FFT.
- fft_source_data  in  38  from FFT: exp in [5:0], real in [21:6], imag in [37:22].
- fft_source_error  in  2  from FFT.
- fft_source_ready  out  1  equal to out_ready.
- out_valid, out_last  out  1  result strobe; out_last marks bin FFT_LEN-1.
- out_exp  out  6  block exponent.
- out_real, out_imag  out  16 each  result components.
- out_bin  out  LOG2_LEN  bin index of the current result.
- out_ready  in  1  consumer ready.
- busy  out  1  state is not IDLE.
- overrun  out  1  sticky status flag.
- frame_err  out  1  sticky status flag.
- frame_cnt  out  16  completed output frames; wraps.

## Operation
Input state machine, with states IDLE, WAIT_SOP, FILL and SKIP:
- IDLE: go to WAIT_SOP when cfg_enable is high and either start is pulsed or cfg_continuous is high.
- WAIT_SOP: when adc_valid and fft_sink_ready are both high, emit the sample with sop, set sample count to 1, go to FILL.
  - A sample with adc_valid high and fft_sink_ready low is silently discarded. It is not an overrun.
- FILL: when adc_valid and fft_sink_ready are both high, emit the sample and increment the count.
  - The sample at count FFT_LEN-1 carries eop.
  - After eop: go to SKIP if cfg_skip is nonzero; otherwise go to WAIT_SOP if cfg_continuous is high; otherwise go to IDLE.
  - If adc_valid is high and fft_sink_ready is low, set overrun and drop the sample; the count does not advance. A frame therefore always contains exactly FFT_LEN samples.
- SKIP: count cfg_skip×FFT_LEN adc_valid strobes (cfg_skip is latched on entry), then go to WAIT_SOP, or to IDLE if cfg_continuous is low.
- cfg_enable low:
  - WAIT_SOP or SKIP: go to IDLE on the next edge.
  - FILL: the frame completes, then the machine goes to IDLE. A partial frame is never sent.
- start while busy is ignored.

Sink outputs are combinational:
- fft_sink_valid = adc_valid & fft_sink_ready & (state is WAIT_SOP or FILL).
- fft_sink_sop and fft_sink_eop are qualified by fft_sink_valid.

Output path is combinational, with zero latency:
- Source fields map to out_*; out_valid = fft_source_valid; fft_source_ready = out_ready.
- The bin counter advances on each fft_source_valid & out_ready beat.
- fft_source_sop forces the bin to 0. out_bin shows 0 on the sop beat.
- On the beat at bin FFT_LEN-1: out_last = 1, the bin counter wraps to 0, and frame_cnt increments.
- frame_err is set when any of these happens:
  - eop is absent at bin FFT_LEN-1;
  - eop arrives at any other bin;
  - sop arrives at a nonzero bin;
  - fft_source_error is nonzero on a valid beat.

Status:
- overrun and frame_err are sticky; only clr_status or reset clears them.
- clr_status has priority over a same-cycle set.
- clr_status zeroes frame_cnt. A same-cycle increment is lost.

## Timing
- Reset values:
  - state IDLE; all counters 0; busy 0; overrun 0; frame_err 0; frame_cnt 0.
  - All fft_sink_* outputs and out_valid are 0. out_* data outputs show the FFT data as passed through.
- adc sample to fft_sink: same cycle.
- fft_source to out_*: same cycle.
- State transitions take effect on the clk edge after the qualifying beat. The first sample after eop can be accepted only on the following edge's state.
- Reset asserted mid-frame aborts immediately. The FFT core is reset from the same reset_n, so no partial-frame recovery is required.

## Structure
- A shared package fft_ctrl_pkg holds:
  - the state enum;
  - the FFT error-code constants;
  - the source-data field offsets: EXP_LSB = 0, REAL_LSB = 6, IMAG_LSB = 22.
- One natural sub-module, fft_bin_tracker: the output bin counter, the framing checker, frame_cnt and frame_err.

## Test plan
All scenarios use FFT_LEN = 16.
- Single shot: start, 16 strobes with ready high → exactly 16 sink beats, sop on the first, eop on the 16th; then busy = 0 and a 17th strobe is not forwarded.
- Backpressure mid-frame: ready low for 3 valid strobes → overrun = 1 and 16 samples still delivered, with the 3 dropped samples absent.
- Decimation: continuous with cfg_skip = 2 over 80 strobes → strobes 1–16 and 49–64 forwarded, nothing else.
- cfg_enable dropped at sample 5 → frame completes through sample 16, then IDLE.
- Output: 16 valid beats with sop and eop, out_ready toggling → out_bin 0..15, out_last on bin 15, frame_cnt = 1.
- Framing errors: eop injected at bin 9 → frame_err = 1. Then clr_status → frame_err = 0 and frame_cnt = 0.
